// File: rtl/atm_pkg.sv
// Shared definitions for the ATM cash dispenser: FSM state encoding and
// reject codes reported back to the controller.
package atm_pkg;

  // Dispenser FSM states; the numeric values are visible on the state port.
  typedef enum logic [2:0] {
    D_IDLE    = 3'd0,
    D_CHECK   = 3'd1,
    D_FEED    = 3'd2,
    D_PRESENT = 3'd3
  } disp_state_t;

  // Reason a withdraw request was refused.
  typedef enum logic [1:0] {
    RJ_NONE       = 2'd0,
    RJ_BAD_AMOUNT = 2'd1,
    RJ_TOO_MANY   = 2'd2,
    RJ_NO_CASH    = 2'd3
  } reject_code_t;

  // Width of note counts (cassette and per-transaction), cassette <= 4095.
  localparam int CNT_W = 12;

endpackage

// File: rtl/atm_note_counter.sv
// Iterative-subtraction validator: turns a requested amount into a note count
// one subtraction per cycle, and decides whether the request can be served.
// The note count is also decremented by the feeder as notes leave.
module atm_note_counter
  import atm_pkg::*;
#(
  parameter int NOTE_VALUE = 100,
  parameter int MAX_NOTES  = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             check_en,
  input  logic             dec,
  input  logic [15:0]      amount,
  input  logic [CNT_W-1:0] avail,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output reject_code_t     err_code
);

  logic [15:0]      rem_r;
  logic [CNT_W-1:0] cnt_r;
  logic             can_sub_s;
  logic             at_max_s;

  assign count = cnt_r;

  // Decide, for the current remainder/count, whether this step subtracts or concludes.
  always_comb begin
    can_sub_s = (rem_r >= 16'(NOTE_VALUE));
    at_max_s  = (cnt_r == CNT_W'(MAX_NOTES));
    done      = 1'b0;
    err_code  = RJ_NONE;
    if (can_sub_s) begin
      if (at_max_s) begin
        done     = check_en;
        err_code = RJ_TOO_MANY;
      end else begin
        done     = 1'b0;
        err_code = RJ_NONE;
      end
    end else if ((rem_r != 16'd0) || (cnt_r == {CNT_W{1'b0}})) begin
      done     = check_en;
      err_code = RJ_BAD_AMOUNT;
    end else if (cnt_r > avail) begin
      done     = check_en;
      err_code = RJ_NO_CASH;
    end else begin
      done     = check_en;
      err_code = RJ_NONE;
    end
  end

  // Remainder and note-count registers: load, subtract step, or feeder decrement.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_r <= 16'd0;
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      rem_r <= amount;
      cnt_r <= {CNT_W{1'b0}};
    end else if (check_en && can_sub_s && !at_max_s) begin
      rem_r <= rem_r - 16'(NOTE_VALUE);
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (dec) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      rem_r <= rem_r;
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/atm_cash_dispenser.sv
// Cash dispenser responder: validates a withdraw amount, feeds notes from the
// cassette at a fixed mechanical rate, presents them and reports completion.
module atm_cash_dispenser
  import atm_pkg::*;
#(
  parameter int NOTE_VALUE     = 100,
  parameter int MAX_NOTES      = 40,
  parameter int CASSETTE_DEPTH = 2000,
  parameter int NOTE_CYCLES    = 4,
  parameter int TAKE_TIMEOUT   = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dispense_req,
  input  logic [15:0] amount,
  input  logic        refill,
  input  logic        cash_taken,
  output logic        busy,
  output logic        note_feed,
  output logic        shutter_open,
  output logic        cash_eject,
  output logic        retract,
  output logic        reject,
  output logic [1:0]  reject_code,
  output logic [11:0] notes_remaining,
  output logic [2:0]  state
);

  disp_state_t      state_r, state_nx_s;
  logic [15:0]      feed_tmr_r, feed_tmr_nx_s;
  logic [31:0]      take_tmr_r, take_tmr_nx_s;
  logic [CNT_W-1:0] notes_r, notes_nx_s;
  reject_code_t     rcode_r, rcode_nx_s;
  logic             eject_r, eject_nx_s;
  logic             retract_r, retract_nx_s;
  logic             load_s, check_en_s, dec_s, done_s;
  logic [CNT_W-1:0] cnt_s;
  reject_code_t     err_s;

  assign check_en_s      = (state_r == D_CHECK);
  assign busy            = (state_r != D_IDLE);
  assign shutter_open    = (state_r == D_PRESENT);
  assign cash_eject      = eject_r;
  assign retract         = retract_r;
  assign reject_code     = rcode_r;
  assign notes_remaining = notes_r;
  assign state           = state_r;

  atm_note_counter #(
    .NOTE_VALUE (NOTE_VALUE),
    .MAX_NOTES  (MAX_NOTES)
  ) u_note_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .check_en (check_en_s),
    .dec      (dec_s),
    .amount   (amount),
    .avail    (notes_r),
    .done     (done_s),
    .count    (cnt_s),
    .err_code (err_s)
  );

  // Next-state and pulse decode for the dispense sequence.
  always_comb begin
    state_nx_s    = state_r;
    feed_tmr_nx_s = feed_tmr_r;
    take_tmr_nx_s = take_tmr_r;
    notes_nx_s    = notes_r;
    rcode_nx_s    = rcode_r;
    eject_nx_s    = 1'b0;
    retract_nx_s  = 1'b0;
    load_s        = 1'b0;
    dec_s         = 1'b0;
    note_feed     = 1'b0;
    reject        = 1'b0;
    case (state_r)
      D_IDLE: begin
        // A request takes priority over a refill in the same cycle.
        if (dispense_req) begin
          load_s     = 1'b1;
          rcode_nx_s = RJ_NONE;
          state_nx_s = D_CHECK;
        end else if (refill) begin
          notes_nx_s = CNT_W'(CASSETTE_DEPTH);
        end else begin
          notes_nx_s = notes_r;
        end
      end
      D_CHECK: begin
        if (done_s) begin
          if (err_s != RJ_NONE) begin
            reject     = 1'b1;
            rcode_nx_s = err_s;
            state_nx_s = D_IDLE;
          end else begin
            feed_tmr_nx_s = 16'd0;
            state_nx_s    = D_FEED;
          end
        end else begin
          state_nx_s = D_CHECK;
        end
      end
      D_FEED: begin
        if (feed_tmr_r == 16'(NOTE_CYCLES - 1)) begin
          note_feed     = 1'b1;
          dec_s         = 1'b1;
          notes_nx_s    = notes_r - {{(CNT_W-1){1'b0}}, 1'b1};
          feed_tmr_nx_s = 16'd0;
          if (cnt_s == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            take_tmr_nx_s = 32'd0;
            state_nx_s    = D_PRESENT;
          end else begin
            state_nx_s = D_FEED;
          end
        end else begin
          feed_tmr_nx_s = feed_tmr_r + 16'd1;
        end
      end
      D_PRESENT: begin
        // Taking the cash wins over a coincident timeout.
        if (cash_taken) begin
          eject_nx_s = 1'b1;
          state_nx_s = D_IDLE;
        end else if (take_tmr_r == 32'(TAKE_TIMEOUT - 1)) begin
          eject_nx_s   = 1'b1;
          retract_nx_s = 1'b1;
          state_nx_s   = D_IDLE;
        end else begin
          take_tmr_nx_s = take_tmr_r + 32'd1;
        end
      end
      default: begin
        state_nx_s = D_IDLE;
      end
    endcase
  end

  // State, timers, cassette count, reject code and registered completion pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= D_IDLE;
      feed_tmr_r <= 16'd0;
      take_tmr_r <= 32'd0;
      notes_r    <= CNT_W'(CASSETTE_DEPTH);
      rcode_r    <= RJ_NONE;
      eject_r    <= 1'b0;
      retract_r  <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      feed_tmr_r <= feed_tmr_nx_s;
      take_tmr_r <= take_tmr_nx_s;
      notes_r    <= notes_nx_s;
      rcode_r    <= rcode_nx_s;
      eject_r    <= eject_nx_s;
      retract_r  <= retract_nx_s;
    end
  end

endmodule

// File: doc/atm_cash_dispenser.md
# atm_cash_dispenser

Responder to the ATM controller's withdraw path. Accepts a requested amount, validates it by iterative subtraction against a fixed note value, feeds notes from a single cassette at a fixed mechanical rate, and presents the cash. It then signals `cash_eject` so the controller can leave its amount-entered state. Sits between the controller FSM and the dispenser mechanism drivers.

## Interface
Parameters:
- `NOTE_VALUE`, 100: currency units per note.
- `MAX_NOTES`, 40: maximum notes per transaction.
- `CASSETTE_DEPTH`, 2000: notes in a full cassette; must be ≤ 4095.
- `NOTE_CYCLES`, 4: clock cycles per note feed; must be ≥ 1.
- `TAKE_TIMEOUT`, 1000: cycles the cash stays presented before it is retracted.

Ports:
- `clk`  in  1  Single clock; everything is on the rising edge.
- `reset`  in  1  Synchronous, active-high.
- `dispense_req`  in  1  Single-cycle request; sampled only in D_IDLE.
- `amount`  in  16  Requested amount in currency units; valid with `dispense_req`.
- `refill`  in  1  Reload cassette to `CASSETTE_DEPTH`; honoured only in D_IDLE.
- `cash_taken`  in  1  Sensor pulse: customer removed the notes.
- `busy`  out  1  High in every state except D_IDLE.
- `note_feed`  out  1  One-cycle pulse per note moved to the presenter.
- `shutter_open`  out  1  High throughout D_PRESENT.
- `cash_eject`  out  1  One-cycle pulse when a dispense completes (taken or retracted).
- `retract`  out  1  One-cycle pulse on timeout retraction; coincides with `cash_eject`.
- `reject`  out  1  One-cycle pulse when a request is refused.
- `reject_code`  out  2  0 none, 1 BAD_AMOUNT, 2 TOO_MANY, 3 NO_CASH.
- `notes_remaining`  out  12  Notes left in the cassette.
- `state`  out  3  Current FSM state.

## Operation
- States: D_IDLE=0, D_CHECK=1, D_FEED=2, D_PRESENT=3.
- D_IDLE, `dispense_req`=1:
  - load `rem` ← `amount` and `cnt` ← 0;
  - clear `reject_code` to 0;
  - go to D_CHECK.
- D_CHECK, one step per cycle, evaluated in this priority order:
  - `rem` ≥ `NOTE_VALUE` and `cnt` == `MAX_NOTES`: reject TOO_MANY, go to D_IDLE.
  - `rem` ≥ `NOTE_VALUE`: `rem` −= `NOTE_VALUE`, `cnt`++.
  - `rem` < `NOTE_VALUE` with `rem` ≠ 0 or `cnt` == 0: reject BAD_AMOUNT, go to D_IDLE.
  - `cnt` > `notes_remaining`: reject NO_CASH, go to D_IDLE.
  - Otherwise: go to D_FEED with feed timer at 0.
- D_FEED:
  - feed timer counts 0 … `NOTE_CYCLES`−1;
  - at `NOTE_CYCLES`−1: pulse `note_feed`, decrement `notes_remaining` and `cnt`, reset the timer;
  - when the last note is fed, go to D_PRESENT with the take timer at 0.
- D_PRESENT:
  - `cash_taken`: pulse `cash_eject`, go to D_IDLE.
  - Else if the take timer == `TAKE_TIMEOUT`−1: pulse `cash_eject` and `retract`, go to D_IDLE. Retracted notes go to the reject bin and are not returned to `notes_remaining`.
- `reject_code` holds its last value until the next accepted request.
- Simultaneous events:
  - `dispense_req` and `refill` together in D_IDLE: the request wins and the refill is dropped.
  - `cash_taken` and timeout in the same cycle: taken wins, no `retract`.
  - `cash_taken` outside D_PRESENT: ignored.
  - `dispense_req` or `refill` while busy: ignored.

## Timing
- Reset values:
  - `state`=D_IDLE;
  - all pulse outputs, `busy` and `shutter_open` = 0;
  - `reject_code`=0;
  - `notes_remaining`=`CASSETTE_DEPTH`;
  - internal counters = 0.
- Reset takes effect on any cycle; a dispense in progress is abandoned with no `cash_eject`.
- Request on cycle t: `busy` goes high at t+1.
- Valid amount of N notes:
  - D_CHECK lasts N+1 cycles;
  - `note_feed` pulses at D_FEED entry + k·`NOTE_CYCLES` − 1, for k = 1..N;
  - D_PRESENT is entered the cycle after the last pulse.
- Rejects:
  - BAD_AMOUNT or NO_CASH pulses on the last D_CHECK cycle, after floor(amount/`NOTE_VALUE`)+1 steps.
  - TOO_MANY pulses on cycle `MAX_NOTES`+1 of D_CHECK.
- `notes_remaining` updates the cycle after each `note_feed` pulse.

## Structure
- Shared package `atm_pkg` holds the dispenser state encoding (D_IDLE..D_PRESENT) and the reject codes (RJ_NONE, RJ_BAD_AMOUNT, RJ_TOO_MANY, RJ_NO_CASH).
- One sub-module, `atm_note_counter`: the iterative-subtraction validator. It owns `rem` and `cnt`, and produces done, count and error-code outputs.
- Feed timer, take timer and cassette count stay in the top-level module.

## Test plan
All scenarios use default parameters unless stated.
- Dispense 300, then `cash_taken` 10 cycles into D_PRESENT:
  - 4 D_CHECK cycles;
  - `note_feed` pulses at D_FEED cycles 3, 7, 11;
  - `notes_remaining` goes 2000→1997;
  - `cash_eject` pulse, `retract`=0.
- Invalid amounts, each on a separate request:
  - 250 → `reject`, code 1, after 3 D_CHECK cycles;
  - 0 → code 1 after 1 cycle;
  - 4100 → code 2 after 41 cycles;
  - `notes_remaining` unchanged in all three cases.
- `CASSETTE_DEPTH`=5:
  - dispense 600 → code 3, count stays 5;
  - then dispense 500 → 5 feeds, count 0;
  - then `refill` → count 5.
- No `cash_taken`: `cash_eject` and `retract` pulse together exactly 1000 cycles after D_PRESENT entry.
- Collisions:
  - `dispense_req`+`refill` in D_IDLE with the cassette at 1990 → dispense proceeds, no refill;
  - `cash_taken` on the timeout cycle → `retract`=0.
- `reset` during D_FEED after 2 notes:
  - next cycle `state`=0, `busy`=0, `notes_remaining`=2000;
  - no `cash_eject`.
